// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: parametrised single-port synchronous SRAM.
//   - Active-low CEN / GWEN / per-bit WEN write semantics.
//   - Hardware self-clear of every entry after reset (INIT_BUSY high while running).
//   - Address holding register, held read data, out-of-range protection.
//   - Optional output pipeline register, enabled by defining CT_SPSRAM_OUT_REG_EN
//     (read/write-through latency becomes 2 cycles instead of 1).
module ct_f_spsram_param #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  // Index width just wide enough for DEPTH entries; never wider than ADDR_WIDTH.
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [IDX_W-1:0]        idx;
  logic                    in_range;
  logic                    acc, wr, clr_we;
  logic [DATA_WIDTH-1:0]   old_word, merged, arr_dout;
  logic [DATA_WIDTH-1:0]   rd_p1_q;

  // Bit-mask merge: bits with active-low enable cleared take new data.
  function automatic logic [DATA_WIDTH-1:0] merge_bits(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [DATA_WIDTH-1:0] wen_n
  );
    return (old_w & wen_n) | (new_w & ~wen_n);
  endfunction

  // Access decode: accesses only count in IDLE and outside reset.
  always_comb begin
    eff_addr = CEN ? hold_q : A;
    in_range = ({1'b0, eff_addr} < DEPTH_A);
    idx      = eff_addr[IDX_W-1:0];
    acc      = (state_q == ST_IDLE) && !RST && !CEN;
    wr       = acc && !GWEN;
    clr_we   = (state_q == ST_CLEAR) && !RST;
    old_word = in_range ? mem[idx] : '0;
    merged   = merge_bits(old_word, D, WEN);
    arr_dout = '0;
    if (in_range) begin
      arr_dout = GWEN ? old_word : merged;
    end
  end

  // Self-clear FSM next state: walk every entry once, then go idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Holding register captures the address of every real access.
  always_comb begin
    hold_d = acc ? A : hold_q;
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Array write port: clear writes have priority; out-of-range writes are dropped.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr && in_range) begin
      mem[idx] <= merged;
    end
  end

  // Stage p1: array output register, only moves on an access so it holds on CEN=1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p1_q <= '0;
    end else if (acc) begin
      rd_p1_q <= arr_dout;
    end
  end

`ifdef CT_SPSRAM_OUT_REG_EN
  logic                  vld_p1_q;
  logic [DATA_WIDTH-1:0] q_p2_q;

  // Stage p2: extra output register, advances only after a cycle that was an access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1_q <= 1'b0;
      q_p2_q   <= '0;
    end else begin
      vld_p1_q <= acc;
      if (vld_p1_q) begin
        q_p2_q <= rd_p1_q;
      end
    end
  end

  assign Q = q_p2_q;
`else
  assign Q = rd_p1_q;
`endif

  assign INIT_BUSY = (state_q == ST_CLEAR);

endmodule
